// File: rtl/vga_pattern_sequencer.sv
// Frame-synchronous test-pattern source for a VGA controller: auto/manual pattern
// sequencing with changes only at frame boundaries. Optional macro PATTERN_BORDER_EN adds a white border.
module vga_pattern_sequencer #(
  parameter int NUM_PATTERNS       = 5,
  parameter int FRAMES_PER_PATTERN = 60,
  parameter int H_ACTIVE           = 640,
  parameter int V_ACTIVE           = 480
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [9:0] pixel_x_i,
  input  logic [9:0] pixel_y_i,
  input  logic       auto_en_i,
  input  logic       hold_i,
  input  logic       step_i,
  output logic [9:0] red_o,
  output logic [9:0] green_o,
  output logic [9:0] blue_o,
  output logic [2:0] pattern_index_o,
  output logic       frame_start_o
);

  localparam int CNT_W = (FRAMES_PER_PATTERN > 1) ? $clog2(FRAMES_PER_PATTERN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAMES_PER_PATTERN - 1);
  localparam logic [2:0]       IDX_LAST = 3'(NUM_PATTERNS - 1);
  localparam logic [9:0]       X_LAST   = 10'(H_ACTIVE - 1);
  localparam logic [9:0]       Y_LAST   = 10'(V_ACTIVE - 1);

  typedef enum logic [1:0] {S_AUTO, S_MANUAL, S_PENDING} state_e;

  state_e           state_q;
  logic [9:0]       prev_y_q;
  logic [CNT_W-1:0] count_q;
  logic [2:0]       index_q;
  logic             frame_start_q;
  logic [9:0]       red_q, green_q, blue_q;
  logic [9:0]       red_d, green_d, blue_d;
  logic             fs;
  logic             active;
  logic [2:0]       index_next;

  // A frame boundary is the Y coordinate wrapping back to line 0.
  assign fs         = (pixel_y_i == 10'd0) && (prev_y_q != 10'd0);
  assign index_next = (index_q == IDX_LAST) ? 3'd0 : index_q + 3'd1;
  assign active     = (pixel_x_i <= X_LAST) && (pixel_y_i <= Y_LAST);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch behind.
    red_d   = '0;
    green_d = '0;
    blue_d  = '0;
    if (active) begin
      case (index_q)
        3'd0: begin
          red_d   = {10{~pixel_x_i[8]}};
          green_d = {10{~pixel_x_i[7]}};
          blue_d  = {10{~pixel_x_i[6]}};
        end
        3'd1: begin
          red_d   = {10{~pixel_y_i[8]}};
          green_d = {10{~pixel_y_i[7]}};
          blue_d  = {10{~pixel_y_i[6]}};
        end
        3'd2: begin
          red_d   = {10{pixel_x_i[5] ^ pixel_y_i[5]}};
          green_d = red_d;
          blue_d  = red_d;
        end
        3'd3:    red_d = pixel_x_i;
        3'd4: begin
          red_d   = 10'h3FF;
          green_d = 10'h3FF;
          blue_d  = 10'h3FF;
        end
        default: ;
      endcase
`ifdef PATTERN_BORDER_EN
      if ((pixel_x_i == 10'd0) || (pixel_x_i == X_LAST) ||
          (pixel_y_i == 10'd0) || (pixel_y_i == Y_LAST)) begin
        red_d   = 10'h3FF;
        green_d = 10'h3FF;
        blue_d  = 10'h3FF;
      end
`endif
    end
  end

  // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= auto_en_i ? S_AUTO : S_MANUAL;
      prev_y_q      <= '0;
      count_q       <= '0;
      index_q       <= '0;
      frame_start_q <= 1'b0;
      red_q         <= '0;
      green_q       <= '0;
      blue_q        <= '0;
    end else begin
      prev_y_q      <= pixel_y_i;
      frame_start_q <= fs;
      red_q         <= red_d;
      green_q       <= green_d;
      blue_q        <= blue_d;
      case (state_q)
        S_AUTO: begin
          if (!auto_en_i) begin
            state_q <= S_MANUAL;
            count_q <= '0;
          end else if (fs && !hold_i) begin
            if (count_q == CNT_LAST) begin
              index_q <= index_next;
              count_q <= '0;
            end else begin
              count_q <= count_q + 1'b1;
            end
          end
        end
        S_MANUAL: begin
          if (auto_en_i) begin
            state_q <= S_AUTO;
            count_q <= '0;
          end else if (step_i) begin
            state_q <= S_PENDING;
          end
        end
        S_PENDING: begin
          // Further step pulses are absorbed here: at most one advance per frame.
          if (auto_en_i) begin
            state_q <= S_AUTO;
            count_q <= '0;
          end else if (fs) begin
            index_q <= index_next;
            state_q <= S_MANUAL;
          end
        end
        default: state_q <= S_MANUAL;
      endcase
    end
  end

  assign red_o           = red_q;
  assign green_o         = green_q;
  assign blue_o          = blue_q;
  assign pattern_index_o = index_q;
  assign frame_start_o   = frame_start_q;

endmodule

// File: tb/tb_vga_pattern_sequencer.sv
// Directed bench for vga_pattern_sequencer: two instances (2 and 1 frames per pattern)
// share stimulus; expected values are hand-computed constants.
module tb_vga_pattern_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] px, py;
  logic       auto_en, hold, step;
  logic [9:0] r0, g0, b0, r1, g1, b1;
  logic [2:0] idx0, idx1;
  logic       fs0, fs1;
  int         total = 0;
  int         bad   = 0;

  always #5 clk = ~clk;

  vga_pattern_sequencer #(.NUM_PATTERNS(5), .FRAMES_PER_PATTERN(2)) dut (
    .clk_i(clk), .reset_i(reset), .pixel_x_i(px), .pixel_y_i(py),
    .auto_en_i(auto_en), .hold_i(hold), .step_i(step),
    .red_o(r0), .green_o(g0), .blue_o(b0),
    .pattern_index_o(idx0), .frame_start_o(fs0)
  );

  vga_pattern_sequencer #(.NUM_PATTERNS(5), .FRAMES_PER_PATTERN(1)) dut1 (
    .clk_i(clk), .reset_i(reset), .pixel_x_i(px), .pixel_y_i(py),
    .auto_en_i(auto_en), .hold_i(hold), .step_i(step),
    .red_o(r1), .green_o(g1), .blue_o(b1),
    .pattern_index_o(idx1), .frame_start_o(fs1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic ae);
    reset = 1'b1; auto_en = ae; hold = 1'b0; step = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  // One full frame: Y sweeps 0..524, one line per cycle; counts pulses seen on dut.
  task automatic sweep_frame(output int pulses);
    pulses = 0;
    for (int y = 0; y < 525; y++) begin
      py = 10'(y);
      tick();
      if (fs0) pulses++;
    end
  endtask

  // Forces one frame boundary cheaply.
  task automatic bump();
    py = 10'd5; tick();
    py = 10'd0; tick();
  endtask

  task automatic test_reset();
    px = 10'd300; py = 10'd100; auto_en = 1'b0; hold = 1'b0; step = 1'b0;
    reset = 1'b1;
    tick(); tick();
    total++; if ({r0, g0, b0} !== 30'h0) begin bad++; $display("FAIL reset_rgb got=%h exp=%h", {r0, g0, b0}, 30'h0); end
    total++; if (idx0 !== 3'd0) begin bad++; $display("FAIL reset_idx got=%0d exp=0", idx0); end
    total++; if (fs0 !== 1'b0) begin bad++; $display("FAIL reset_fs got=%b exp=0", fs0); end
    reset = 1'b0; py = 10'd0;
    tick(); tick();
    total++; if (fs0 !== 1'b0) begin bad++; $display("FAIL no_pulse_after_reset got=%b exp=0", fs0); end
    py = 10'd100; tick();
    total++; if ({r0, g0, b0} !== {10'h000, 10'h3FF, 10'h3FF}) begin bad++; $display("FAIL pat0_x300 got=%h exp=%h", {r0, g0, b0}, {10'h000, 10'h3FF, 10'h3FF}); end
    total++; if (idx0 !== 3'd0) begin bad++; $display("FAIL pat0_idx got=%0d exp=0", idx0); end
    px = 10'd100; tick();
    total++; if ({r0, g0, b0} !== {10'h3FF, 10'h3FF, 10'h000}) begin bad++; $display("FAIL pat0_x100 got=%h exp=%h", {r0, g0, b0}, {10'h3FF, 10'h3FF, 10'h000}); end
    px = 10'd700; tick();
    total++; if ({r0, g0, b0} !== 30'h0) begin bad++; $display("FAIL pat0_x700 got=%h exp=0", {r0, g0, b0}); end
    px = 10'd100; py = 10'd600; tick();
    total++; if ({r0, g0, b0} !== 30'h0) begin bad++; $display("FAIL pat0_y600 got=%h exp=0", {r0, g0, b0}); end
  endtask

  task automatic test_auto();
    int p;
    px = 10'd300; py = 10'd0;
    do_reset(1'b1);
    for (int f = 1; f <= 6; f++) begin
      sweep_frame(p);
      total++; if (p !== ((f == 1) ? 0 : 1)) begin bad++; $display("FAIL auto_pulses f=%0d got=%0d exp=%0d", f, p, (f == 1) ? 0 : 1); end
      total++; if (idx0 !== 3'((f - 1) / 2)) begin bad++; $display("FAIL auto_idx_fpp2 f=%0d got=%0d exp=%0d", f, idx0, (f - 1) / 2); end
      total++; if (idx1 !== 3'((f - 1) % 5)) begin bad++; $display("FAIL auto_idx_fpp1 f=%0d got=%0d exp=%0d", f, idx1, (f - 1) % 5); end
    end
  endtask

  task automatic test_manual();
    py = 10'd0;
    do_reset(1'b0);
    for (int y = 0; y < 200; y++) begin py = 10'(y); tick(); end
    py = 10'd200;
    for (int k = 0; k < 3; k++) begin
      step = 1'b1; tick();
      step = 1'b0; tick();
    end
    for (int y = 201; y < 525; y++) begin py = 10'(y); tick(); end
    total++; if (idx0 !== 3'd0) begin bad++; $display("FAIL manual_before_fs got=%0d exp=0", idx0); end
    py = 10'd0; tick();
    total++; if (fs0 !== 1'b1) begin bad++; $display("FAIL manual_fs got=%b exp=1", fs0); end
    total++; if (idx0 !== 3'd1) begin bad++; $display("FAIL manual_adv got=%0d exp=1", idx0); end
    for (int y = 1; y < 525; y++) begin py = 10'(y); tick(); end
    py = 10'd0; step = 1'b1; tick();
    step = 1'b0;
    total++; if (idx0 !== 3'd1) begin bad++; $display("FAIL step_with_fs got=%0d exp=1", idx0); end
    for (int y = 1; y < 525; y++) begin py = 10'(y); tick(); end
    py = 10'd0; tick();
    total++; if (idx0 !== 3'd2) begin bad++; $display("FAIL step_with_fs_next got=%0d exp=2", idx0); end
    // Reset while a request is pending must discard it.
    do_reset(1'b0);
    py = 10'd200; tick();
    step = 1'b1; tick();
    step = 1'b0; tick();
    reset = 1'b1; tick();
    reset = 1'b0; py = 10'd300; tick();
    py = 10'd0; tick();
    total++; if (fs0 !== 1'b1) begin bad++; $display("FAIL reset_pending_fs got=%b exp=1", fs0); end
    total++; if (idx0 !== 3'd0) begin bad++; $display("FAIL reset_pending_idx got=%0d exp=0", idx0); end
  endtask

  task automatic test_hold();
    int p;
    py = 10'd0;
    do_reset(1'b1);
    sweep_frame(p);
    sweep_frame(p);
    hold = 1'b1;
    for (int f = 0; f < 10; f++) begin
      sweep_frame(p);
      total++; if (idx0 !== 3'd0) begin bad++; $display("FAIL hold_idx_fpp2 f=%0d got=%0d exp=0", f, idx0); end
      total++; if (idx1 !== 3'd1) begin bad++; $display("FAIL hold_idx_fpp1 f=%0d got=%0d exp=1", f, idx1); end
    end
    hold = 1'b0;
    py = 10'd0; tick();
    total++; if (idx0 !== 3'd1) begin bad++; $display("FAIL hold_resume_fpp2 got=%0d exp=1", idx0); end
    total++; if (idx1 !== 3'd2) begin bad++; $display("FAIL hold_resume_fpp1 got=%0d exp=2", idx1); end
  endtask

  task automatic test_patterns();
    logic [29:0] exp;
    py = 10'd0;
    do_reset(1'b1);
    px = 10'd300; py = 10'd100; tick();
    total++; if ({r1, g1, b1} !== {10'h000, 10'h3FF, 10'h3FF}) begin bad++; $display("FAIL p0 got=%h exp=%h", {r1, g1, b1}, {10'h000, 10'h3FF, 10'h3FF}); end
    bump();
    total++; if (idx1 !== 3'd1) begin bad++; $display("FAIL p1_idx got=%0d exp=1", idx1); end
    px = 10'd300; py = 10'd100; tick();
    total++; if ({r1, g1, b1} !== {10'h3FF, 10'h3FF, 10'h000}) begin bad++; $display("FAIL p1_y100 got=%h exp=%h", {r1, g1, b1}, {10'h3FF, 10'h3FF, 10'h000}); end
    py = 10'd200; tick();
    total++; if ({r1, g1, b1} !== {10'h3FF, 10'h000, 10'h000}) begin bad++; $display("FAIL p1_y200 got=%h exp=%h", {r1, g1, b1}, {10'h3FF, 10'h000, 10'h000}); end
    bump();
    px = 10'd32; py = 10'd100; tick();
    total++; if ({r1, g1, b1} !== 30'h0) begin bad++; $display("FAIL p2_same got=%h exp=0", {r1, g1, b1}); end
    py = 10'd64; tick();
    total++; if ({r1, g1, b1} !== {3{10'h3FF}}) begin bad++; $display("FAIL p2_diff got=%h exp=%h", {r1, g1, b1}, {3{10'h3FF}}); end
    bump();
    px = 10'd639; py = 10'd479; tick();
`ifdef PATTERN_BORDER_EN
    exp = {3{10'h3FF}};
`else
    exp = {10'd639, 10'h000, 10'h000};
`endif
    total++; if ({r1, g1, b1} !== exp) begin bad++; $display("FAIL p3_corner got=%h exp=%h", {r1, g1, b1}, exp); end
    px = 10'd0; py = 10'd100; tick();
`ifdef PATTERN_BORDER_EN
    exp = {3{10'h3FF}};
`else
    exp = 30'h0;
`endif
    total++; if ({r1, g1, b1} !== exp) begin bad++; $display("FAIL p3_left got=%h exp=%h", {r1, g1, b1}, exp); end
    px = 10'd100; tick();
    total++; if ({r1, g1, b1} !== {10'd100, 10'h000, 10'h000}) begin bad++; $display("FAIL p3_x100 got=%h exp=%h", {r1, g1, b1}, {10'd100, 10'h000, 10'h000}); end
    px = 10'd700; tick();
    total++; if ({r1, g1, b1} !== 30'h0) begin bad++; $display("FAIL p3_x700 got=%h exp=0", {r1, g1, b1}); end
    px = 10'd100; py = 10'd480; tick();
    total++; if ({r1, g1, b1} !== 30'h0) begin bad++; $display("FAIL p3_y480 got=%h exp=0", {r1, g1, b1}); end
    bump();
    px = 10'd300; py = 10'd100; tick();
    total++; if ({r1, g1, b1} !== {3{10'h3FF}}) begin bad++; $display("FAIL p4_white got=%h exp=%h", {r1, g1, b1}, {3{10'h3FF}}); end
    bump();
    total++; if (idx1 !== 3'd0) begin bad++; $display("FAIL wrap_idx got=%0d exp=0", idx1); end
  endtask

  initial begin
    reset = 1'b1; px = '0; py = '0; auto_en = 1'b0; hold = 1'b0; step = 1'b0;
    test_reset();
    test_auto();
    test_manual();
    test_hold();
    test_patterns();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_pattern_sequencer.md
Name: vga_pattern_sequencer

Overview:
- Frame-synchronous controller that sequences a set of test patterns into the VGA controller's iRed/iGreen/iBlue inputs.
- Inputs are the controller's pixel coordinates (oCoord_X/oCoord_Y); outputs are registered 10-bit RGB.
- Pattern changes happen only at frame boundaries, never mid-frame, so no tearing.
- Two modes: auto (advance every N frames) or manual (advance on a step request).

Parameters:
- NUM_PATTERNS, 5, number of patterns cycled (1..8); index wraps at NUM_PATTERNS-1.
- FRAMES_PER_PATTERN, 60, frames each pattern is shown in auto mode (>=1).
- H_ACTIVE, 640, active pixels per line.
- V_ACTIVE, 480, active lines per frame.

Ports:
- Clock  input  1  system clock (50 MHz).
- Reset  input  1  synchronous, active-high reset.
- Pixel_X  input  10  current X coordinate from VGA controller.
- Pixel_Y  input  10  current Y coordinate from VGA controller.
- Auto_en  input  1  1 = auto mode, 0 = manual mode.
- Hold  input  1  freezes the auto frame counter; pattern is held.
- Step  input  1  single-cycle manual advance request.
- Red  output  10  pattern red to VGA controller iRed.
- Green  output  10  pattern green to VGA controller iGreen.
- Blue  output  10  pattern blue to VGA controller iBlue.
- Pattern_index  output  3  currently displayed pattern.
- Frame_start  output  1  one-cycle pulse at each detected frame boundary.

Behaviour:
- Reset (synchronous, active-high):
  - Red/Green/Blue = 0.
  - Pattern_index = 0, Frame_start = 0.
  - Frame counter = 0, prev_Y register = 0.
  - State = S_MANUAL if Auto_en = 0, else S_AUTO.
  - Reset asserted mid-frame takes effect on the next edge; the pending request is discarded.
- Frame detection:
  - fs = (Pixel_Y == 0) && (prev_Y != 0), with prev_Y registered every cycle.
  - Frame_start = fs registered (one-cycle pulse).
  - No pulse is generated until the first Y wrap after reset.
- States:
  - S_AUTO:
    - On fs with Hold = 0: if count == FRAMES_PER_PATTERN-1, advance the index and clear count; else count+1.
    - Hold = 1: count frozen.
    - Step is ignored.
    - Auto_en = 0 -> S_MANUAL, count cleared.
  - S_MANUAL:
    - Step = 1 -> S_PENDING.
    - Auto_en = 1 -> S_AUTO, count = 0.
  - S_PENDING:
    - On fs, advance the index and go to S_MANUAL.
    - Extra Step pulses while pending are absorbed, so there is one advance per frame maximum.
    - Auto_en = 1 -> S_AUTO; the pending request is dropped.
  - Step and fs in the same cycle while in S_MANUAL: go to S_PENDING only; the advance happens at the next fs.
- Advance rule: index = (index == NUM_PATTERNS-1) ? 0 : index+1. Pattern_index updates the cycle after the fs cycle.
- Patterns (combinational from Pixel_X/Pixel_Y/index, then registered; RGB latency = 1 cycle from coordinates):
  - 0: vertical colour bars. R = {10{~X[8]}}, G = {10{~X[7]}}, B = {10{~X[6]}}.
  - 1: horizontal bars. Same form as pattern 0 using Y[8], Y[7], Y[6].
  - 2: checkerboard. All channels = {10{X[5]^Y[5]}}.
  - 3: gradient. R = X, G = 0, B = 0 (X max 639 fits 10 bits).
  - 4: solid white, all channels = 10'h3FF.
  - 5..7: black.
- Outside active area (X >= H_ACTIVE or Y >= V_ACTIVE): RGB = 0.

Optional Feature:
- Macro: PATTERN_BORDER_EN.
- Defined: pixels with X == 0, X == H_ACTIVE-1, Y == 0 or Y == V_ACTIVE-1 output 10'h3FF on all channels, overriding the pattern. Same 1-cycle latency.
- Undefined: no border logic; the pattern covers the full active area.

Test Plan:
- Reset, then drive X = 300, Y = 100 -> after 1 cycle RGB = (0x000, 0x3FF, 0x3FF) for pattern 0 (X[8] = 1, X[7] = 0, X[6] = 0); Pattern_index = 0.
- Auto_en = 1, FRAMES_PER_PATTERN = 2; sweep Y 0..524 for 5 frames -> Pattern_index goes 0, 1, 2 at the 2nd and 4th Frame_start pulses.
- Auto_en = 1, NUM_PATTERNS = 5, FRAMES_PER_PATTERN = 1 -> Pattern_index sequence 1, 2, 3, 4, 0 across successive frames (wrap checked).
- Manual mode: pulse Step three times mid-frame at Y = 200 -> exactly one advance, 0 -> 1, one cycle after the next Frame_start.
- Auto_en = 1 with Hold = 1 for 10 frames -> Pattern_index constant; release Hold -> counting resumes from the held count.
- Pattern 3 with X = 639, Y = 479 -> Red = 639; with PATTERN_BORDER_EN defined -> all channels = 0x3FF. X = 700 -> RGB = 0.
